// File: rtl/fb_display_reader_pkg.sv
// rtl/fb_display_reader_pkg.sv - shared encodings and colour-bar table for the frame-buffer scan-out engine
package fb_display_reader_pkg;

  typedef enum logic [1:0] {
    MODE_RGB444 = 2'd0,
    MODE_GREY   = 2'd1,
    MODE_BARS   = 2'd2,
    MODE_BLACK  = 2'd3
  } mode_e;

  typedef enum logic {
    S_DELAY = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  // Entry 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][23:0] BAR_COLOURS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic logic [23:0] expand_rgb444(input logic [11:0] pix);
    return {{2{pix[11:8]}}, {2{pix[7:4]}}, {2{pix[3:0]}}};
  endfunction

endpackage

// File: rtl/fb_rd_align.sv
// rtl/fb_rd_align.sv - DEPTH x WIDTH shift register that delays raster timing by the frame-buffer read latency
module fb_rd_align #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/fb_display_reader.sv
// rtl/fb_display_reader.sv - raster timing, frame-buffer addressing, startup blanking and pixel formatting
module fb_display_reader
  import fb_display_reader_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIX_W      = 12,
  parameter int RD_LAT     = 1,
  parameter int START_FRMS = 2,
  parameter int ADDR_W     = 19
) (
  input  logic              i_p_clk,
  input  logic              i_rstn,
  input  logic              i_enable,
  input  logic [1:0]        i_mode,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [PIX_W-1:0]  i_rdata,
  output logic [7:0]        o_red,
  output logic [7:0]        o_green,
  output logic [7:0]        o_blue,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_active,
  output logic              o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int FW      = (START_FRMS > 1) ? $clog2(START_FRMS + 1) : 1;
  localparam int BW      = XW + 3;
  localparam int DW      = XW + 4;

  localparam logic [XW-1:0]     X_LAST    = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0]     X_ACT     = XW'(H_ACTIVE);
  localparam logic [XW-1:0]     HS_BEG    = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0]     HS_END    = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0]     Y_LAST    = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0]     Y_ACT     = YW'(V_ACTIVE);
  localparam logic [YW-1:0]     VS_BEG    = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0]     VS_END    = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [FW-1:0]     FRMS_INIT = FW'(START_FRMS);
  localparam logic [FW-1:0]     FRMS_ONE  = FW'(1);
  localparam state_e            STATE_INIT = (START_FRMS == 0) ? S_RUN : S_DELAY;
  localparam logic [DW-1:0]     ALIGN_RST = {1'b0, 1'b1, 1'b1, 1'b0, {XW{1'b0}}};

  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic              frame_end;
  logic              raw_active;
  logic              raw_hsync;
  logic              raw_vsync;
  logic              raw_fs;
  logic [ADDR_W-1:0] addr_q;

  state_e            state_q;
  state_e            state_d;
  logic [FW-1:0]     frm_cnt_q;
  logic [FW-1:0]     frm_cnt_d;
  mode_e             cur_mode;
  logic              cur_en;

  logic              d_active;
  logic              d_hsync;
  logic              d_vsync;
  logic              d_fs;
  logic [XW-1:0]     d_x;
  logic [2:0]        bar_idx;
  logic [23:0]       pix_rgb;

  assign frame_end  = (x_q == X_LAST) && (y_q == Y_LAST);
  assign raw_active = (x_q < X_ACT) && (y_q < Y_ACT);
  assign raw_hsync  = !((x_q >= HS_BEG) && (x_q < HS_END));
  assign raw_vsync  = !((y_q >= VS_BEG) && (y_q < VS_END));
  assign raw_fs     = (x_q == '0) && (y_q == '0);

  always_ff @(posedge i_p_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      x_q <= '0;
      y_q <= '0;
    end else if (x_q == X_LAST) begin
      x_q <= '0;
      y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
    end else begin
      x_q <= x_q + 1'b1;
    end
  end

  // Address tracks the next visible pixel, so it already holds the right index when a line starts
  always_ff @(posedge i_p_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      addr_q <= '0;
    end else if (frame_end) begin
      addr_q <= '0;
    end else if (raw_active) begin
      addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
    end
  end

  assign o_raddr = addr_q;

  always_ff @(posedge i_p_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= STATE_INIT;
      frm_cnt_q <= FRMS_INIT;
      cur_mode  <= MODE_RGB444;
      cur_en    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frm_cnt_q <= frm_cnt_d;
      if (frame_end) begin
        cur_mode <= mode_e'(i_mode);
        cur_en   <= i_enable;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    frm_cnt_d = frm_cnt_q;
    if (frame_end && state_q == S_DELAY) begin
      if (frm_cnt_q == FRMS_ONE || frm_cnt_q == '0) begin
        frm_cnt_d = '0;
        state_d   = S_RUN;
      end else begin
        frm_cnt_d = frm_cnt_q - 1'b1;
      end
    end
  end

  fb_rd_align #(
    .DEPTH   (RD_LAT),
    .WIDTH   (DW),
    .RST_VAL (ALIGN_RST)
  ) u_align (
    .clk   (i_p_clk),
    .rst_n (i_rstn),
    .din   ({raw_active, raw_hsync, raw_vsync, raw_fs, x_q}),
    .dout  ({d_active, d_hsync, d_vsync, d_fs, d_x})
  );

  // Eight equal bars: bar = x * 8 / H_ACTIVE
  assign bar_idx = 3'({d_x, 3'b000} / BW'(H_ACTIVE));

  always_comb begin
    pix_rgb = '0;
    if (d_active && cur_en && state_q == S_RUN) begin
      case (cur_mode)
        MODE_RGB444: pix_rgb = expand_rgb444(i_rdata[11:0]);
        MODE_GREY:   pix_rgb = {3{i_rdata[PIX_W-1 -: 8]}};
        MODE_BARS:   pix_rgb = BAR_COLOURS[bar_idx];
        default:     pix_rgb = '0;
      endcase
    end
  end

  always_ff @(posedge i_p_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
      o_hsync       <= 1'b1;
      o_vsync       <= 1'b1;
      o_active      <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      {o_red, o_green, o_blue} <= pix_rgb;
      o_hsync       <= d_hsync;
      o_vsync       <= d_vsync;
      o_active      <= d_active;
      o_frame_start <= d_fs;
    end
  end

endmodule

// File: tb/tb_fb_display_reader.sv
// tb/tb_fb_display_reader.sv - directed self-checking bench for fb_display_reader at read latencies 1 and 3
module tb_fb_display_reader;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FR = HT * VT;
  localparam logic [27:0] RST_OUT = {1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        use_const = 1'b0;

  logic [4:0]  raddr1, raddr3;
  logic [11:0] rdata1, rdata3;
  logic [4:0]  pipe1;
  logic [4:0]  pipe3 [3];
  logic [7:0]  r1, g1, b1, r3, g3, b3;
  logic        hs1, vs1, act1, fs1, hs3, vs3, act3, fs3;
  logic [27:0] obs1, obs3;

  int n_checks = 0;
  int n_fail = 0;
  int cur_pos = 0;
  int mode_tab [10];
  int en_tab [10];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe1    <= raddr1;
    pipe3[0] <= raddr3;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign rdata1 = use_const ? 12'hAB5 : {7'd0, pipe1};
  assign rdata3 = use_const ? 12'hAB5 : {7'd0, pipe3[2]};
  assign obs1 = {act1, hs1, vs1, fs1, r1, g1, b1};
  assign obs3 = {act3, hs3, vs3, fs3, r3, g3, b3};

  fb_display_reader #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_W(12), .RD_LAT(1), .START_FRMS(2), .ADDR_W(5)
  ) u_dut1 (
    .i_p_clk(clk), .i_rstn(rstn), .i_enable(en), .i_mode(mode),
    .o_raddr(raddr1), .i_rdata(rdata1),
    .o_red(r1), .o_green(g1), .o_blue(b1),
    .o_hsync(hs1), .o_vsync(vs1), .o_active(act1), .o_frame_start(fs1)
  );

  fb_display_reader #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_W(12), .RD_LAT(3), .START_FRMS(2), .ADDR_W(5)
  ) u_dut3 (
    .i_p_clk(clk), .i_rstn(rstn), .i_enable(en), .i_mode(mode),
    .o_raddr(raddr3), .i_rdata(rdata3),
    .o_red(r3), .o_green(g3), .o_blue(b3),
    .o_hsync(hs3), .o_vsync(vs3), .o_active(act3), .o_frame_start(fs3)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s pos=%0d got=%h expected=%h", tag, cur_pos, obs, exp);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected outputs after posedge p for read latency lat: they reflect counter position p-(lat+1)
  function automatic logic [27:0] exp_out(input int p, input int lat);
    int q, f, x, y, k;
    logic act, hs, vs, fs;
    logic [7:0] kk;
    logic [23:0] rgb;
    q = p - (lat + 1);
    if (q < 0) return RST_OUT;
    f = q / FR;
    x = q % HT;
    y = (q / HT) % VT;
    act = (x < 8) && (y < 4);
    hs = !(x == 10 || x == 11);
    vs = (y != 5);
    fs = (x == 0) && (y == 0);
    rgb = 24'h000000;
    if (act && f >= 2 && en_tab[f] != 0) begin
      k = y * 8 + x;
      kk = 8'(k);
      case (mode_tab[f])
        0: rgb = {8'h00, {2{kk[7:4]}}, {2{kk[3:0]}}};
        1: rgb = 24'hABABAB;
        2: rgb = bar_rgb(x);
        default: rgb = 24'h000000;
      endcase
    end
    return {act, hs, vs, fs, rgb};
  endfunction

  function automatic int exp_addr(input int p);
    int x, y;
    x = p % HT;
    y = (p / HT) % VT;
    if (y < 4) return (y * 8 + ((x < 8) ? x : 8)) % 32;
    return 0;
  endfunction

  task automatic check_reset_state(input string tag);
    check_val({tag, "_out1"}, {4'd0, obs1}, {4'd0, RST_OUT});
    check_val({tag, "_out3"}, {4'd0, obs3}, {4'd0, RST_OUT});
    check_val({tag, "_addr1"}, 32'(raddr1), 32'd0);
    check_val({tag, "_addr3"}, 32'(raddr3), 32'd0);
  endtask

  task automatic stim(input int p);
    if (p == 3 * FR + 20) begin
      mode = 2'd3;
      en = 1'b0;
    end else if (p == 4 * FR + 70) begin
      mode = 2'd1;
      en = 1'b1;
      use_const = 1'b1;
    end else if (p == 5 * FR + 70) begin
      mode = 2'd2;
    end else if (p == 6 * FR + 56) begin
      use_const = 1'b0;
    end
  endtask

  task automatic run_phase(input int ncyc, input bit drive);
    for (int p = 1; p <= ncyc; p++) begin
      @(posedge clk);
      @(negedge clk);
      cur_pos = p;
      check_val("out_lat1", {4'd0, obs1}, {4'd0, exp_out(p, 1)});
      check_val("out_lat3", {4'd0, obs3}, {4'd0, exp_out(p, 3)});
      check_val("addr_lat1", 32'(raddr1), 32'(exp_addr(p)));
      check_val("addr_lat3", 32'(raddr3), 32'(exp_addr(p)));
      if (drive) stim(p);
    end
  endtask

  initial begin
    mode_tab = '{0, 0, 0, 0, 3, 1, 2, 2, 2, 2};
    en_tab   = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rstn = 1'b1;
    run_phase(7 * FR + 17, 1'b1);

    #2 rstn = 1'b0;
    #1 check_reset_state("midline_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst_hold");
    mode_tab = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
    en_tab   = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    rstn = 1'b1;
    run_phase(3 * FR + 10, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
